// File: rtl/d2l_pkg.sv
// Shared definitions for the D2L dual-lane serial link (master and slave).
package d2l_pkg;
  localparam int D2L_DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } d2l_state_t;

  localparam logic CS_ACTIVE = 1'b0;
endpackage

// File: rtl/d2l_sync.sv
// Two-flop synchronizer for a group of asynchronous pins, with a per-bit reset value.
module d2l_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1, r_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/d2l_slave.sv
// D2L receiver: synchronizes sclk/CS/DL1/DL0, shifts two bits per sclk rise
// and emits each completed word with a one-cycle valid strobe.
module d2l_slave
  import d2l_pkg::*;
#(
  parameter int DATA_W = D2L_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              CS,
  input  logic              DL0,
  input  logic              DL1,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);
  localparam int               CNT_W = $clog2(DATA_W/2) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W/2 - 1);

  logic [3:0] w_sync;
  logic       w_cs_s, w_sclk_s, w_dl1_s, w_dl0_s, w_sclk_rise;

  // CS idles high so a reset never looks like the start of a frame
  d2l_sync #(.W(4), .RST_VAL(4'b1000)) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   ({CS, sclk, DL1, DL0}),
    .o_q   (w_sync)
  );

  assign {w_cs_s, w_sclk_s, w_dl1_s, w_dl0_s} = w_sync;

  d2l_state_t        r_state, w_state_nxt;
  logic              r_sclk_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt, w_pair_word;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_frame_err, w_frame_err_nxt;
  logic              r_busy;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_pair_word = DATA_W'({r_shreg, w_dl1_s, w_dl0_s});

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shreg_nxt     = r_shreg;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_s == CS_ACTIVE) begin
          w_state_nxt = RECV;
          w_cnt_nxt   = '0;
          w_shreg_nxt = '0;
        end
      end
      RECV: begin
        if (w_sclk_rise) begin
          w_shreg_nxt = w_pair_word;
          if (r_cnt == LAST) begin
            w_cnt_nxt      = '0;
            w_rx_data_nxt  = w_pair_word;
            w_rx_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        // The edge is folded in first, so a word finishing with CS rise is not an error
        if (w_cs_s != CS_ACTIVE) begin
          w_state_nxt     = IDLE;
          w_frame_err_nxt = (w_cnt_nxt != '0);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sclk_d    <= 1'b0;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sclk_d    <= w_sclk_s;
      r_cnt       <= w_cnt_nxt;
      r_shreg     <= w_shreg_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_busy      <= (r_state == RECV);
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;
endmodule

// File: tb/tb_d2l_slave.sv
// Directed plus random frames for d2l_slave, checked against a word-level model.
module tb_d2l_slave;
  logic       clk = 1'b0;
  logic       rst, sclk, CS, DL0, DL1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  int errors = 0;
  int checks = 0;

  d2l_slave #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .CS(CS), .DL0(DL0), .DL1(DL1),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observed events
  int         cyc = 0;
  logic [7:0] obs_q[$];
  int         obs_t[$];
  int         obs_fe = 0;
  int         obs_both = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        obs_q.push_back(rx_data);
        obs_t.push_back(cyc);
      end
      if (frame_err) obs_fe = obs_fe + 1;
      if (rx_valid && frame_err) obs_both = obs_both + 1;
    end
  end

  // Reference model: a word is four 2-bit digits, most significant first
  int         m_cnt = 0;
  int         m_acc = 0;
  logic [7:0] exp_q[$];
  int         exp_fe = 0;
  logic [7:0] exp_last = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_pair(input logic b1, input logic b0, input bit model);
    DL1 = b1; DL0 = b0;
    #20 sclk = 1'b1;
    #20 sclk = 1'b0;
    if (model) begin
      m_acc = m_acc * 4 + 2 * int'(b1) + int'(b0);
      m_cnt++;
      if (m_cnt == 4) begin
        exp_q.push_back(8'(m_acc));
        exp_last = 8'(m_acc);
        m_cnt = 0;
        m_acc = 0;
      end
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 3; k >= 0; k--) send_pair(w[2*k+1], w[2*k], 1'b1);
  endtask

  task automatic frame_start();
    CS = 1'b0;
    #40;
  endtask

  task automatic frame_end();
    #20 CS = 1'b1;
    if (m_cnt != 0) exp_fe++;
    m_cnt = 0;
    m_acc = 0;
  endtask

  task automatic check_scn(input string tag);
    int n;
    #200;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    chk({tag, " words"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) chk({tag, " data"}, obs_q[i], exp_q[i]);
    chk({tag, " frame_err"}, obs_fe, exp_fe);
    chk({tag, " rx_data hold"}, rx_data, exp_last);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " valid&err"}, obs_both, 0);
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    obs_fe = 0; exp_fe = 0;
  endtask

  initial begin
    int d;
    rst = 1'b1; sclk = 1'b0; CS = 1'b1; DL0 = 1'b0; DL1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single word A5
    frame_start();
    send_pair(1, 0, 1); send_pair(1, 0, 1); send_pair(0, 1, 1); send_pair(0, 1, 1);
    chk("single busy in frame", busy, 1'b1);
    frame_end();
    check_scn("single");

    // Burst: 3C then C3 in one frame, 4 sclk periods apart
    frame_start();
    send_word(8'h3C);
    send_word(8'hC3);
    frame_end();
    #200;
    d = (obs_t.size() >= 2) ? obs_t[1] - obs_t[0] : -1;
    chk("burst spacing", d, 16);
    check_scn("burst");

    // Aborted after 2 pairs
    frame_start();
    send_pair(1, 1, 1); send_pair(0, 1, 1);
    frame_end();
    check_scn("abort");

    // Reset mid-word, then a clean 5A frame
    frame_start();
    send_pair(0, 1, 1); send_pair(0, 1, 1); send_pair(1, 0, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("in-reset rx_data", rx_data, 8'h00);
    chk("in-reset rx_valid", rx_valid, 1'b0);
    chk("in-reset frame_err", frame_err, 1'b0);
    chk("in-reset busy", busy, 1'b0);
    rst = 1'b0;
    m_cnt = 0; m_acc = 0; exp_last = 8'h00;
    @(negedge clk);
    chk("post-reset rx_data", rx_data, 8'h00);
    chk("post-reset rx_valid", rx_valid, 1'b0);
    chk("post-reset frame_err", frame_err, 1'b0);
    frame_end();
    #100;
    frame_start();
    send_word(8'h5A);
    frame_end();
    check_scn("rst-mid");

    // sclk activity with CS high is ignored
    for (int i = 0; i < 6; i++) send_pair(i[0], ~i[0], 1'b0);
    check_scn("cs-high sclk");

    // CS rises together with the 4th sclk rise
    frame_start();
    send_pair(1, 1, 1); send_pair(0, 0, 1); send_pair(1, 0, 1);
    DL1 = 1'b0; DL0 = 1'b1;
    #20 begin sclk = 1'b1; CS = 1'b1; end
    m_acc = m_acc * 4 + 1; m_cnt = 0;
    exp_q.push_back(8'(m_acc)); exp_last = 8'(m_acc); m_acc = 0;
    #20 sclk = 1'b0;
    check_scn("cs+edge");

    // Random frames, some with a trailing partial word
    for (int r = 0; r < 6; r++) begin
      int nw;
      nw = $urandom_range(1, 3);
      frame_start();
      for (int w = 0; w < nw; w++) send_word(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        int np;
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) send_pair(1'($urandom), 1'($urandom), 1'b1);
      end
      frame_end();
      check_scn("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
